// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter.
// Holds the controller state encoding, the ASCII constants used by the
// character lookup, and the packed {valid, len, pat} code word. The same
// code-word layout is used by the interpreter's decode path, so it lives here.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MARK       = 3'd1,
        ST_SYM_GAP    = 3'd2,
        ST_LETTER_GAP = 3'd3,
        ST_WORD_GAP   = 3'd4,
        ST_ERR        = 3'd5
    } morse_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_UC_A  = 8'h41;
    localparam logic [7:0] ASCII_UC_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam int MAX_SYMS = 5;

    // One encoded character: pat[len-1] is the first symbol, 1 = dah.
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

endpackage

// File: rtl/morse_encode_rom.sv
// Combinational ASCII to Morse lookup.
// Ports:
//   ascii_i      - character to encode
//   code_valid_o - 1 for A-Z, a-z, 0-9
//   code_len_o   - number of symbols (0 when invalid)
//   code_pat_o   - symbols, first at code_pat_o[len-1], 1 = dah, 0 = dit
module morse_encode_rom
    import morse_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic       code_valid_o,
    output logic [2:0] code_len_o,
    output logic [4:0] code_pat_o
);

    logic [7:0]  upper_s;
    morse_code_t code_s;

    // Fold lowercase onto uppercase before the table lookup.
    always_comb begin
        upper_s = ascii_i;
        if ((ascii_i >= ASCII_LC_A) && (ascii_i <= ASCII_LC_Z)) begin
            upper_s = ascii_i - 8'h20;
        end else begin
            upper_s = ascii_i;
        end
    end

    // Character table.
    always_comb begin
        code_s = '{valid: 1'b0, len: 3'd0, pat: 5'b00000};
        case (upper_s)
            8'h41: code_s = {1'b1, 3'd2, 5'b00001}; // A .-
            8'h42: code_s = {1'b1, 3'd4, 5'b01000}; // B -...
            8'h43: code_s = {1'b1, 3'd4, 5'b01010}; // C -.-.
            8'h44: code_s = {1'b1, 3'd3, 5'b00100}; // D -..
            8'h45: code_s = {1'b1, 3'd1, 5'b00000}; // E .
            8'h46: code_s = {1'b1, 3'd4, 5'b00010}; // F ..-.
            8'h47: code_s = {1'b1, 3'd3, 5'b00110}; // G --.
            8'h48: code_s = {1'b1, 3'd4, 5'b00000}; // H ....
            8'h49: code_s = {1'b1, 3'd2, 5'b00000}; // I ..
            8'h4A: code_s = {1'b1, 3'd4, 5'b00111}; // J .---
            8'h4B: code_s = {1'b1, 3'd3, 5'b00101}; // K -.-
            8'h4C: code_s = {1'b1, 3'd4, 5'b00100}; // L .-..
            8'h4D: code_s = {1'b1, 3'd2, 5'b00011}; // M --
            8'h4E: code_s = {1'b1, 3'd2, 5'b00010}; // N -.
            8'h4F: code_s = {1'b1, 3'd3, 5'b00111}; // O ---
            8'h50: code_s = {1'b1, 3'd4, 5'b00110}; // P .--.
            8'h51: code_s = {1'b1, 3'd4, 5'b01101}; // Q --.-
            8'h52: code_s = {1'b1, 3'd3, 5'b00010}; // R .-.
            8'h53: code_s = {1'b1, 3'd3, 5'b00000}; // S ...
            8'h54: code_s = {1'b1, 3'd1, 5'b00001}; // T -
            8'h55: code_s = {1'b1, 3'd3, 5'b00001}; // U ..-
            8'h56: code_s = {1'b1, 3'd4, 5'b00001}; // V ...-
            8'h57: code_s = {1'b1, 3'd3, 5'b00011}; // W .--
            8'h58: code_s = {1'b1, 3'd4, 5'b01001}; // X -..-
            8'h59: code_s = {1'b1, 3'd4, 5'b01011}; // Y -.--
            8'h5A: code_s = {1'b1, 3'd4, 5'b01100}; // Z --..
            8'h30: code_s = {1'b1, 3'd5, 5'b11111}; // 0 -----
            8'h31: code_s = {1'b1, 3'd5, 5'b01111}; // 1 .----
            8'h32: code_s = {1'b1, 3'd5, 5'b00111}; // 2 ..---
            8'h33: code_s = {1'b1, 3'd5, 5'b00011}; // 3 ...--
            8'h34: code_s = {1'b1, 3'd5, 5'b00001}; // 4 ....-
            8'h35: code_s = {1'b1, 3'd5, 5'b00000}; // 5 .....
            8'h36: code_s = {1'b1, 3'd5, 5'b10000}; // 6 -....
            8'h37: code_s = {1'b1, 3'd5, 5'b11000}; // 7 --...
            8'h38: code_s = {1'b1, 3'd5, 5'b11100}; // 8 ---..
            8'h39: code_s = {1'b1, 3'd5, 5'b11110}; // 9 ----.
            default: code_s = {1'b0, 3'd0, 5'b00000};
        endcase
    end

    assign code_valid_o = code_s.valid;
    assign code_len_o   = code_s.len;
    assign code_pat_o   = code_s.pat;

endmodule

// File: rtl/morse_code_transmitter.sv
// Morse keying transmitter: accepts one ASCII character per handshake and
// plays it out on morse_out as marks and gaps of fixed cycle counts.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   char_in     - ASCII character, captured when char_valid && char_ready
//   char_valid  - char_in is valid
//   char_ready  - high only while idle
//   morse_out   - keying output (1 = tone)
//   busy        - character (including its trailing gap) in progress
//   char_err    - one-cycle pulse for an accepted unencodable character
module morse_code_transmitter
    import morse_pkg::*;
#(
    parameter int unsigned DIT_CYCLES        = 6,
    parameter int unsigned DAH_CYCLES        = 8,
    parameter int unsigned SYM_GAP_CYCLES    = 2,
    parameter int unsigned LETTER_GAP_CYCLES = 20,
    parameter int unsigned WORD_GAP_CYCLES   = 40,
    parameter int unsigned CNT_W             = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       morse_out,
    output logic       busy,
    output logic       char_err
);

    // Counters are loaded with N-1 and the state is left when they hit zero,
    // giving exactly N cycles per phase.
    localparam logic [CNT_W-1:0] DIT_LOAD    = CNT_W'(DIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAH_LOAD    = CNT_W'(DAH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYM_LOAD    = CNT_W'(SYM_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LETTER_LOAD = CNT_W'(LETTER_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_LOAD   = CNT_W'(WORD_GAP_CYCLES - 1);

    morse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pat_q, pat_d;     // current symbol always at bit 4
    logic [2:0]       left_q, left_d;   // symbols remaining after the current one
    logic             morse_q, morse_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             rom_valid_s;
    logic [2:0]       rom_len_s;
    logic [4:0]       rom_pat_s;
    logic [4:0]       rom_aligned_s;

    morse_encode_rom u_rom (
        .ascii_i      (char_in),
        .code_valid_o (rom_valid_s),
        .code_len_o   (rom_len_s),
        .code_pat_o   (rom_pat_s)
    );

    // Left-justify the pattern so the first symbol sits at bit 4.
    assign rom_aligned_s = rom_pat_s << (3'd5 - rom_len_s);

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        left_d  = left_q;
        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    if (rom_valid_s) begin
                        state_d = ST_MARK;
                        pat_d   = rom_aligned_s;
                        left_d  = rom_len_s - 3'd1;
                        cnt_d   = rom_aligned_s[4] ? DAH_LOAD : DIT_LOAD;
                    end else if (char_in == ASCII_SPACE) begin
                        state_d = ST_WORD_GAP;
                        cnt_d   = WORD_LOAD;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (cnt_q == '0) begin
                    if (left_q != 3'd0) begin
                        state_d = ST_SYM_GAP;
                        cnt_d   = SYM_LOAD;
                    end else begin
                        // Letter gap takes the place of the symbol gap.
                        state_d = ST_LETTER_GAP;
                        cnt_d   = LETTER_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SYM_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_MARK;
                    pat_d   = pat_q << 1;
                    left_d  = left_q - 3'd1;
                    cnt_d   = pat_q[3] ? DAH_LOAD : DIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LETTER_GAP, ST_WORD_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so morse_out rises on
        // the accepting edge.
        morse_d = (state_d == ST_MARK);
        err_d   = (state_d == ST_ERR);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= 5'b00000;
            left_q  <= 3'd0;
            morse_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            left_q  <= left_d;
            morse_q <= morse_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign morse_out  = morse_q;
    assign char_err   = err_q;
    assign busy       = busy_q;
    assign char_ready = ~busy_q;

endmodule

// File: tb/tb_morse_code_transmitter.sv
module tb_morse_code_transmitter;

    localparam int DIT    = 6;
    localparam int DAH    = 8;
    localparam int SYMG   = 2;
    localparam int LETG   = 20;
    localparam int WORDG  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready, morse_out, busy, char_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] trace;
        int           len;
        int           errs;
        int           idle_before;
    } exp_t;

    exp_t exp_q[$];

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    morse_code_transmitter dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .morse_out  (morse_out),
        .busy       (busy),
        .char_err   (char_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: waveform of one character built from the Morse string.
    function automatic exp_t build_exp(input logic [7:0] c, input int idle_before);
        exp_t       e;
        logic [7:0] u;
        string      s;
        int         n;
        e.trace = '0;
        e.len = 0;
        e.errs = 0;
        e.idle_before = idle_before;
        s = "";
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        if (u >= 8'h41 && u <= 8'h5A) s = morse_tab[int'(u) - 8'h41];
        else if (u >= 8'h30 && u <= 8'h39) s = morse_tab[26 + int'(u) - 8'h30];
        if (s.len() != 0) begin
            for (int i = 0; i < s.len(); i++) begin
                n = (s[i] == "-") ? DAH : DIT;
                for (int k = 0; k < n; k++) begin
                    e.trace[e.len] = 1'b1;
                    e.len++;
                end
                if (i != s.len() - 1) e.len += SYMG;
            end
            e.len += LETG;
        end else if (u == 8'h20) begin
            e.len = WORDG;
        end else begin
            e.len = 1;
            e.errs = 1;
        end
        return e;
    endfunction

    // Drive one character; returns just after the accepting edge.
    task automatic send(input logic [7:0] c, input int idle_before, input bit hold);
        int guard;
        char_in = c;
        char_valid = 1'b1;
        guard = 0;
        while (!char_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!char_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 for char %h", c);
        end else begin
            exp_q.push_back(build_exp(c, idle_before));
            @(posedge clk);
            #1;
        end
        if (!hold) char_valid = 1'b0;
    endtask

    // Monitor: collects each busy window and compares it with the scoreboard.
    initial begin : monitor
        logic [127:0] obs_trace;
        int obs_len, obs_err, idle_cnt, idle_at_start;
        bit in_tx;
        exp_t e;
        in_tx = 1'b0; obs_trace = '0; obs_len = 0; obs_err = 0;
        idle_cnt = 0; idle_at_start = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_tx = 1'b0;
                idle_cnt = 0;
            end else begin
                check("ready_vs_busy", char_ready, !busy);
                if (busy) begin
                    if (!in_tx) begin
                        in_tx = 1'b1;
                        obs_trace = '0;
                        obs_len = 0;
                        obs_err = 0;
                        idle_at_start = idle_cnt;
                    end
                    if (obs_len < 128) obs_trace[obs_len] = morse_out;
                    obs_len++;
                    obs_err += int'(char_err);
                end else begin
                    check("idle_quiet", {morse_out, char_err}, 0);
                    if (in_tx) begin
                        in_tx = 1'b0;
                        idle_cnt = 0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_tx: got len=%0d expected none", obs_len);
                        end else begin
                            e = exp_q.pop_front();
                            check("busy_len", obs_len, e.len);
                            check_vec("trace", obs_trace, e.trace);
                            check("err_pulses", obs_err, e.errs);
                            if (e.idle_before >= 0) check("idle_bubble", idle_at_start, e.idle_before);
                        end
                    end
                    idle_cnt++;
                end
            end
        end
    end

    initial begin : stimulus
        bit         prev_hold;
        bit         hold;
        logic [7:0] c;
        int         cat;

        repeat (3) @(posedge clk);
        #1;
        check("rst_morse", morse_out, 0);
        check("rst_ready", char_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", char_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(8'h48, -1, 1'b0);             // H
        repeat (60) @(negedge clk);
        send(8'h54, -1, 1'b1);             // T, valid held
        send(8'h45, 1, 1'b0);              // E right after one idle cycle
        repeat (40) @(negedge clk);
        send(8'h30, -1, 1'b0);             // 0
        repeat (80) @(negedge clk);
        send(8'h61, -1, 1'b1);             // a
        send(8'h20, 1, 1'b0);              // space
        repeat (50) @(negedge clk);
        send(8'h23, -1, 1'b0);             // #
        repeat (5) @(negedge clk);

        // Reset in the middle of Q's second dah.
        send(8'h51, -1, 1'b0);
        repeat (13) @(posedge clk);
        #3;
        check("q_dah2_high", morse_out, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("abort_morse", morse_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", char_ready, 1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_morse", morse_out, 0);
        check("post_rst_busy", busy, 0);
        send(8'h45, -1, 1'b0);             // E
        repeat (30) @(negedge clk);

        // Randomized characters, some back-to-back.
        prev_hold = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cat = $urandom_range(0, 5);
            case (cat)
                0: c = 8'h41 + 8'($urandom_range(0, 25));
                1: c = 8'h61 + 8'($urandom_range(0, 25));
                2: c = 8'h30 + 8'($urandom_range(0, 9));
                3: c = 8'h20;
                4: c = 8'($urandom_range(0, 255));
                default: c = 8'h41 + 8'($urandom_range(0, 25));
            endcase
            hold = 1'($urandom_range(0, 1));
            send(c, prev_hold ? 1 : -1, hold);
            prev_hold = hold;
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        char_valid = 1'b0;

        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
